// File: rtl/axi_lite_apb_bridge_mc.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_apb_bridge_mc
//  Description : AXI4-Lite slave to multi-slave APB4 master bridge. The AXI
//                address is decoded into NUM_SLAVES APB windows.
//                addr[SLOT_LSB +: SEL_W] selects the target slot.
//                One APB transfer is in flight at a time.
//                Supports wait states, PSTRB, PPROT and per-slave error return.
//  Options     : APB_TIMEOUT_EN - when defined, ACCESS is aborted with SLVERR
//                after TIMEOUT_CYC cycles without PREADY.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_apb_bridge_mc #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int SLOT_LSB    = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    // AXI4-Lite write address / data / response
    input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
    input  logic [2:0]                       s_axi_awprot,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    // AXI4-Lite read address / data
    input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
    input  logic [2:0]                       s_axi_arprot,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    // APB4 master
    output logic [ADDR_WIDTH-1:0]            m_apb_paddr,
    output logic [NUM_SLAVES-1:0]            m_apb_psel,
    output logic                             m_apb_penable,
    output logic                             m_apb_pwrite,
    output logic [DATA_WIDTH-1:0]            m_apb_pwdata,
    output logic [DATA_WIDTH/8-1:0]          m_apb_pstrb,
    output logic [2:0]                       m_apb_pprot,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_apb_prdata,
    input  logic [NUM_SLAVES-1:0]            m_apb_pready,
    input  logic [NUM_SLAVES-1:0]            m_apb_pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic                    awready_q, awready_d;
    logic                    wready_q,  wready_d;
    logic                    arready_q, arready_d;
    logic                    bvalid_q,  bvalid_d;
    logic                    rvalid_q,  rvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
    logic [STRB_W-1:0]       pstrb_q,   pstrb_d;
    logic [2:0]              pprot_q,   pprot_d;
    logic                    pwrite_q,  pwrite_d;
    logic [NUM_SLAVES-1:0]   psel_q,    psel_d;
    logic                    penable_q, penable_d;
    logic [SEL_W-1:0]        slot_q,    slot_d;
    // Winner of the most recent contested arbitration (1 = write)
    logic                    last_wr_q, last_wr_d;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0]         tcnt_q,    tcnt_d;
`endif

    logic                    w_wr_elig;
    logic                    w_rd_elig;
    logic                    w_grant_wr;
    logic [SEL_W-1:0]        w_aw_slot;
    logic [SEL_W-1:0]        w_ar_slot;
    logic                    w_pready;
    logic                    w_pslverr;
    logic [DATA_WIDTH-1:0]   w_prdata;

    assign w_wr_elig  = s_axi_awvalid & s_axi_wvalid;
    assign w_rd_elig  = s_axi_arvalid;
    // On a tie, serve the opposite of the previous contested winner
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~last_wr_q);
    assign w_aw_slot  = (NUM_SLAVES == 1) ? '0 : s_axi_awaddr[SLOT_LSB +: SEL_W];
    assign w_ar_slot  = (NUM_SLAVES == 1) ? '0 : s_axi_araddr[SLOT_LSB +: SEL_W];

    // Route the selected slave's ready/error/read data; others are ignored
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == SEL_W'(i)) begin
                w_pready  = m_apb_pready[i];
                w_pslverr = m_apb_pslverr[i];
                w_prdata  = m_apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and datapath decisions for the IDLE/SETUP/ACCESS/RESP sequence
    always_comb begin
        state_d   = state_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        arready_d = 1'b0;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        slot_d    = slot_q;
        last_wr_d = last_wr_q;
`ifdef APB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (awready_q || arready_q) begin
                    // Ready pulse is up this cycle: the handshake completes now
                    if (awready_q && s_axi_awvalid && s_axi_wvalid) begin
                        paddr_d  = s_axi_awaddr;
                        pwdata_d = s_axi_wdata;
                        pstrb_d  = s_axi_wstrb;
                        pprot_d  = s_axi_awprot;
                        pwrite_d = 1'b1;
                        slot_d   = w_aw_slot;
                        psel_d   = NUM_SLAVES'(1) << w_aw_slot;
                        state_d  = S_SETUP;
                    end else if (arready_q && s_axi_arvalid) begin
                        paddr_d  = s_axi_araddr;
                        pstrb_d  = '0;
                        pprot_d  = s_axi_arprot;
                        pwrite_d = 1'b0;
                        slot_d   = w_ar_slot;
                        psel_d   = NUM_SLAVES'(1) << w_ar_slot;
                        state_d  = S_SETUP;
                    end
                end else if (w_grant_wr) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    if (w_rd_elig) begin
                        last_wr_d = 1'b1;
                    end
                end else if (w_rd_elig) begin
                    arready_d = 1'b1;
                    if (w_wr_elig) begin
                        last_wr_d = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            S_ACCESS: begin
                if (w_pready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = S_RESP;
                    if (pwrite_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = w_pslverr ? 2'b10 : 2'b00;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = w_pslverr ? 2'b10 : 2'b00;
                        rdata_d  = w_prdata;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Slave never answered: abandon the transfer with SLVERR
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = S_RESP;
                    if (pwrite_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = 2'b10;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b10;
                        rdata_d  = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if ((bvalid_q && s_axi_bready) || (rvalid_q && s_axi_rready)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset returns everything to idle at once
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= 3'b000;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            slot_q    <= '0;
            last_wr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            slot_q    <= slot_d;
            last_wr_q <= last_wr_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;
    assign m_apb_pprot   = pprot_q;

endmodule
`default_nettype wire
